// File: rtl/mem_arbiter_rr_pkg.sv
// Shared definitions for the four-port round-robin memory arbiter.
//   - sizing constants for the CPU ports and the shared memory
//   - state_t : arbiter FSM states
//   - port_idx_t : index of one CPU port
package mem_arb_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 8;
  localparam int MEM_DEPTH  = 32;
  localparam int MEM_ADDR_W = 5;

  typedef logic [1:0] port_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Bus bundle between the CPU request ports, the arbiter and the memory.
//   CPU side : REQ, RW, ADDRESS, data_in (to arbiter); ACK, data_out, ERR (from arbiter)
//   Mem side : mem_en, mem_we, mem_addr, mem_wdata (from arbiter); mem_rdata (to arbiter)
//
// Handshake: a CPU raises REQ[i] (acting as valid) together with RW/ADDRESS/data_in
// and holds all of them stable until it samples ACK[i] high. ACK[i] is a single-cycle
// completion pulse; data_out and ERR are valid only in that cycle. The CPU drops REQ[i]
// in the cycle after ACK (or keeps it high to start a new transaction). There is no
// separate ready: the arbiter latches the request when it grants it, so a REQ dropped
// after the grant still completes and is ACKed.
interface mem_arbiter_rr_if;
  import mem_arb_pkg::*;

  logic [NUM_PORTS-1:0]             REQ;
  logic [NUM_PORTS-1:0]             RW;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] ADDRESS;
  logic [NUM_PORTS-1:0][DATA_W-1:0] data_in;
  logic [NUM_PORTS-1:0]             ACK;
  logic [DATA_W-1:0]                data_out;
  logic                             ERR;

  logic                             mem_en;
  logic                             mem_we;
  logic [MEM_ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]                mem_wdata;
  logic [DATA_W-1:0]                mem_rdata;

  // Arbiter view.
  modport slave (
    input  REQ, RW, ADDRESS, data_in, mem_rdata,
    output ACK, data_out, ERR, mem_en, mem_we, mem_addr, mem_wdata
  );

  // CPU + memory environment view.
  modport master (
    output REQ, RW, ADDRESS, data_in, mem_rdata,
    input  ACK, data_out, ERR, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_rr_arbiter.sv
// Combinational round-robin pick.
//   req        : per-port request vector
//   last_grant : port granted most recently (lowest priority next time)
//   any_req    : at least one request present
//   winner     : first requesting port searching last_grant+1 .. last_grant+4 (mod 4)
module rr_arbiter
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            last_grant,
  output logic                 any_req,
  output port_idx_t            winner
);

  port_idx_t idx;

  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      // 2-bit wraparound gives the mod-4 search order for free.
      idx = last_grant + port_idx_t'(k);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter serialising four CPU request ports onto one 32-word memory.
//   clock, RESET : rising-edge clock, synchronous active-high reset
//   bus          : CPU request/ACK bundle plus memory port (slave modport)
//   BUSY         : transaction in flight (state != IDLE)
//   GRANT_ID     : port currently being served, valid while BUSY
//   fsm_state    : current FSM state, for observation
// Latency from the IDLE cycle that samples REQ: write ACK +2, read ACK +3,
// out-of-range ACK +1 (memory untouched, ERR=1, data_out cleared).
module mem_arbiter_rr
  import mem_arb_pkg::*;
(
  input  logic              clock,
  input  logic              RESET,
  mem_arbiter_rr_if.slave   bus,
  output logic              BUSY,
  output port_idx_t         GRANT_ID,
  output state_t            fsm_state
);

  state_t                state, state_nxt;
  port_idx_t             last_grant;
  port_idx_t             id;
  logic                  rw_q;
  logic                  err_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     data_out_q;

  logic                  any_req;
  port_idx_t             winner;
  logic                  in_range;

  rr_arbiter u_rr (
    .req        (bus.REQ),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner)
  );

  // Range check is on the full CPU address, before truncation to the memory width.
  assign in_range = (bus.ADDRESS[winner] < ADDR_W'(MEM_DEPTH));

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = in_range ? ISSUE : RESP;
      ISSUE:   state_nxt = rw_q ? RESP : WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs, all zero in IDLE so the reset state needs no extra registers.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.ACK       = '0;
    bus.ERR       = 1'b0;
    if (state == ISSUE) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = rw_q;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
    end
    if (state == RESP) begin
      bus.ACK[id] = 1'b1;
      bus.ERR     = err_q;
    end
  end

  assign bus.data_out = data_out_q;
  assign BUSY         = (state != IDLE);
  assign GRANT_ID     = id;
  assign fsm_state    = state;

  always_ff @(posedge clock) begin
    if (RESET) begin
      state      <= IDLE;
      last_grant <= 2'd3;
      id         <= '0;
      rw_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            id      <= winner;
            rw_q    <= bus.RW[winner];
            addr_q  <= bus.ADDRESS[winner][MEM_ADDR_W-1:0];
            wdata_q <= bus.data_in[winner];
            err_q   <= !in_range;
            // Out-of-range requests report zero data in their RESP cycle.
            if (!in_range) data_out_q <= '0;
          end
        end
        // Memory returns read data one cycle after the ISSUE strobe.
        WAIT:    data_out_q <= bus.mem_rdata;
        RESP:    last_grant <= id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Self-checking bench for mem_arbiter_rr: a transaction-level reference model
// predicts every output cycle from the arbitration rules; directed scenarios add
// hand-computed literal checks (latency, order, data).
module tb_mem_arbiter_rr;
  import mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic      clock = 1'b0;
  logic      RESET;
  logic      BUSY;
  port_idx_t GRANT_ID;
  state_t    fsm_state;

  mem_arbiter_rr_if bus ();

  mem_arbiter_rr dut (
    .clock     (clock),
    .RESET     (RESET),
    .bus       (bus),
    .BUSY      (BUSY),
    .GRANT_ID  (GRANT_ID),
    .fsm_state (fsm_state)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int t0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory environment ----------------
  logic [7:0] env_mem [32] = '{default: 8'h00};
  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= env_mem[bus.mem_addr];
    end
  end

  int mem_en_cnt = 0;
  int mem_en_cyc = -1;
  always @(negedge clock) begin
    if (bus.mem_en === 1'b1) begin
      mem_en_cnt++;
      mem_en_cyc = cyc;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0] ack;
    logic       err;
    logic       busy;
    logic [1:0] gid;
    logic [7:0] dout;
    logic       en;
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] model_mem [32] = '{default: 8'h00};
  logic [7:0] model_dout = 8'h00;
  int         model_last = 3;
  bit         model_valid = 1'b0;

  function automatic exp_t mk(logic [3:0] ack, logic err, logic busy, int gid, logic [7:0] dout,
                              logic en, logic we, logic [4:0] addr, logic [7:0] wdata);
    exp_t e;
    e.ack = ack; e.err = err; e.busy = busy; e.gid = gid[1:0]; e.dout = dout;
    e.en = en; e.we = we; e.addr = addr; e.wdata = wdata;
    return e;
  endfunction

  // The queue holds the expected outputs of each cycle of the transaction being
  // served; an empty queue means the arbiter is idle.
  always @(posedge clock) begin
    int         w;
    logic       rw;
    logic [7:0] a;
    logic [7:0] d;
    logic [3:0] oh;
    if (RESET) begin
      exp_q.delete();
      model_last  = 3;
      model_dout  = 8'h00;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end else if (bus.REQ != 4'b0000) begin
        w = -1;
        for (int k = 1; k <= 4; k++)
          if (w < 0 && bus.REQ[(model_last + k) % 4]) w = (model_last + k) % 4;
        model_last = w;
        rw = bus.RW[w];
        a  = bus.ADDRESS[w];
        d  = bus.data_in[w];
        oh = 4'(1 << w);
        if (a >= 8'd32) begin
          model_dout = 8'h00;
          exp_q.push_back(mk(oh, 1'b1, 1'b1, w, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00));
        end else begin
          exp_q.push_back(mk(4'b0, 1'b0, 1'b1, w, model_dout, 1'b1, rw, a[4:0], d));
          if (rw) begin
            model_mem[a[4:0]] = d;
          end else begin
            exp_q.push_back(mk(4'b0, 1'b0, 1'b1, w, model_dout, 1'b0, 1'b0, 5'd0, 8'h00));
            model_dout = model_mem[a[4:0]];
          end
          exp_q.push_back(mk(oh, 1'b0, 1'b1, w, model_dout, 1'b0, 1'b0, 5'd0, 8'h00));
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    exp_t e;
    if (model_valid) begin
      if (exp_q.size() != 0) e = exp_q[0];
      else e = mk(4'b0, 1'b0, 1'b0, 0, model_dout, 1'b0, 1'b0, 5'd0, 8'h00);
      chk("ACK", bus.ACK, e.ack);
      chk("ERR", bus.ERR, e.err);
      chk("BUSY", BUSY, e.busy);
      chk("data_out", bus.data_out, e.dout);
      chk("mem_en", bus.mem_en, e.en);
      chk("mem_we", bus.mem_we, e.we);
      if (e.busy) chk("GRANT_ID", GRANT_ID, e.gid);
      if (e.en) begin
        chk("mem_addr", bus.mem_addr, e.addr);
        chk("mem_wdata", bus.mem_wdata, e.wdata);
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic       ack_err;
  logic [7:0] ack_dout;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_port(input int p, input logic rw, input logic [7:0] a, input logic [7:0] d);
    bus.REQ[p]     = 1'b1;
    bus.RW[p]      = rw;
    bus.ADDRESS[p] = a;
    bus.data_in[p] = d;
  endtask

  task automatic do_reset();
    RESET   = 1'b1;
    bus.REQ = '0;
    step();
    step();
    RESET = 1'b0;
  endtask

  // Waits for the next ACK; returns the acked port and latency from t0.
  task automatic wait_ack(input int budget, input bit drop, output int port, output int lat);
    port = -1;
    lat  = -1;
    for (int i = 0; i < budget && port < 0; i++) begin
      @(negedge clock);
      if (bus.ACK != 4'b0000) begin
        for (int p = 0; p < NUM_PORTS; p++) if (bus.ACK[p]) port = p;
        lat      = cyc - t0;
        ack_err  = bus.ERR;
        ack_dout = bus.data_out;
      end
    end
    if (port < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no ACK within %0d cycles, required one", budget);
    end else begin
      step();
      if (drop) bus.REQ[port] = 1'b0;
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int port, lat;
    int exp_port [5] = '{0, 1, 2, 3, 0};
    int exp_lat  [5] = '{2, 5, 8, 11, 14};

    RESET       = 1'b1;
    bus.REQ     = '0;
    bus.RW      = '0;
    bus.ADDRESS = '0;
    bus.data_in = '0;
    step();
    step();
    @(negedge clock);
    chk("rst_ACK", bus.ACK, 4'b0000);
    chk("rst_BUSY", BUSY, 1'b0);
    chk("rst_ERR", bus.ERR, 1'b0);
    chk("rst_GRANT_ID", GRANT_ID, 2'd0);
    chk("rst_data_out", bus.data_out, 8'h00);
    chk("rst_mem_en", bus.mem_en, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 5'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 8'h00);
    step();
    RESET = 1'b0;

    // 1: port 2 writes 0xA5 to address 5.
    set_port(2, 1'b1, 8'h05, 8'hA5);
    t0 = cyc;
    mem_en_cnt = 0;
    @(negedge clock);
    chk("t1_c0_mem_en", bus.mem_en, 1'b0);
    @(negedge clock);
    chk("t1_c1_mem_en", bus.mem_en, 1'b1);
    chk("t1_c1_mem_we", bus.mem_we, 1'b1);
    chk("t1_c1_mem_addr", bus.mem_addr, 5'd5);
    chk("t1_c1_mem_wdata", bus.mem_wdata, 8'hA5);
    chk("t1_c1_GRANT_ID", GRANT_ID, 2'd2);
    @(negedge clock);
    chk("t1_c2_ACK", bus.ACK, 4'b0100);
    chk("t1_c2_ERR", bus.ERR, 1'b0);
    step();
    bus.REQ[2] = 1'b0;
    @(negedge clock);
    chk("t1_c3_BUSY", BUSY, 1'b0);

    // 2: port 1 reads address 5.
    step();
    set_port(1, 1'b0, 8'h05, 8'h00);
    t0 = cyc;
    mem_en_cnt = 0;
    wait_ack(8, 1'b1, port, lat);
    chk("t2_port", port, 1);
    chk("t2_lat", lat, 3);
    chk("t2_data", ack_dout, 8'hA5);
    chk("t2_mem_en_cnt", mem_en_cnt, 1);
    chk("t2_mem_en_cyc", mem_en_cyc - t0, 1);

    // 5: reset during WAIT of a read, then ports 0 and 3 together.
    step();
    set_port(0, 1'b0, 8'h05, 8'h00);
    t0 = cyc;
    step();
    step();
    chk("t5_in_wait", fsm_state, WAIT);
    RESET   = 1'b1;
    bus.REQ = '0;
    step();
    RESET = 1'b0;
    @(negedge clock);
    chk("t5_ACK", bus.ACK, 4'b0000);
    chk("t5_BUSY", BUSY, 1'b0);
    chk("t5_data_out", bus.data_out, 8'h00);
    chk("t5_mem_en", bus.mem_en, 1'b0);
    step();
    set_port(0, 1'b1, 8'h03, 8'h33);
    set_port(3, 1'b1, 8'h04, 8'h44);
    t0 = cyc;
    wait_ack(8, 1'b1, port, lat);
    chk("t5_first", port, 0);
    wait_ack(8, 1'b1, port, lat);
    chk("t5_second", port, 3);

    // 6: port 0 re-requests right after its ACK while port 2 waits.
    set_port(0, 1'b1, 8'h01, 8'h61);
    set_port(2, 1'b1, 8'h02, 8'h62);
    t0 = cyc;
    wait_ack(8, 1'b0, port, lat);
    chk("t6_first", port, 0);
    bus.data_in[0] = 8'h71;
    wait_ack(8, 1'b1, port, lat);
    chk("t6_second", port, 2);
    wait_ack(8, 1'b1, port, lat);
    chk("t6_third", port, 0);
    set_port(1, 1'b0, 8'h01, 8'h00);
    t0 = cyc;
    wait_ack(8, 1'b1, port, lat);
    chk("t6_read_data", ack_dout, 8'h71);

    // 3: all four ports write continuously after reset.
    do_reset();
    for (int p = 0; p < 4; p++) set_port(p, 1'b1, 8'(8 + p), 8'(16 * p + 1));
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      wait_ack(6, 1'b0, port, lat);
      chk("t3_order", port, exp_port[i]);
      chk("t3_ack_cycle", lat, exp_lat[i]);
    end
    bus.REQ = '0;
    step();
    set_port(1, 1'b0, 8'h09, 8'h00);
    t0 = cyc;
    wait_ack(8, 1'b1, port, lat);
    chk("t3_readback", ack_dout, 8'h11);

    // 4: out-of-range read from port 3.
    step();
    set_port(3, 1'b0, 8'h20, 8'h00);
    t0 = cyc;
    mem_en_cnt = 0;
    wait_ack(6, 1'b1, port, lat);
    chk("t4_port", port, 3);
    chk("t4_lat", lat, 1);
    chk("t4_ERR", ack_err, 1'b1);
    chk("t4_data", ack_dout, 8'h00);
    chk("t4_mem_en_cnt", mem_en_cnt, 0);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
Round-robin arbiter between the four CPU request ports and the single shared 8-bit data memory. Each CPU raises REQ with RW, ADDRESS and data_in. The arbiter serialises requests onto one memory port and returns a one-cycle ACK to the winning CPU, with read data on data_out. It sits directly downstream of the CPU REQ/ACK handshake and upstream of the memory.

Parameters:
NUM_PORTS, 4, number of requesting CPUs
DATA_W, 8, data width
ADDR_W, 8, CPU address width
MEM_DEPTH, 32, valid words; ADDRESS >= MEM_DEPTH is out of range
MEM_ADDR_W, 5, memory address width (log2 MEM_DEPTH)

Ports:
clock  in  1  system clock, rising edge
RESET  in  1  synchronous reset, active-high
REQ  in  [NUM_PORTS]  per-CPU request, held until ACK
RW  in  [NUM_PORTS]  1 = write, 0 = read
ADDRESS  in  [NUM_PORTS][ADDR_W]  per-CPU address
data_in  in  [NUM_PORTS][DATA_W]  per-CPU write data
ACK  out  [NUM_PORTS]  one-cycle completion pulse to the granted CPU
data_out  out  DATA_W  read data, valid with ACK
ERR  out  1  out-of-range flag, pulses with ACK
BUSY  out  1  transaction in flight
GRANT_ID  out  2  index of the current winner
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  MEM_ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en with mem_we = 0

Behaviour:
- Reset (synchronous, RESET = 1 at the rising edge):
  - state = IDLE.
  - ACK, ERR, BUSY, GRANT_ID, data_out, mem_en, mem_we, mem_addr, mem_wdata all 0.
  - last_grant = 3, so port 0 has first priority.
  - An in-flight access is abandoned; a write already issued to memory may still land.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any REQ is high, pick the winner by round-robin: search order last_grant+1, +2, +3, +4 (mod 4).
  - Latch id, RW, ADDRESS and data_in.
  - If the latched ADDRESS < MEM_DEPTH, go to ISSUE; otherwise go to RESP with the error flag set.
- ISSUE (exactly one cycle):
  - mem_en = 1, mem_we = latched RW, mem_addr = ADDRESS[MEM_ADDR_W-1:0], mem_wdata = latched data.
  - Write goes to RESP; read goes to WAIT.
- WAIT: capture mem_rdata into data_out, go to RESP.
- RESP:
  - ACK[id] = 1 for exactly one cycle.
  - ERR = 1 only for an out-of-range request; in that case data_out = 0.
  - A write leaves data_out unchanged.
  - last_grant = id, then go to IDLE.
- Output timing:
  - mem_en and mem_we are high only in ISSUE.
  - BUSY = (state != IDLE).
  - GRANT_ID is valid while BUSY.
- Latency, with REQ sampled in IDLE at cycle 0:
  - Write: ACK in cycle 2.
  - Read: ACK in cycle 3.
  - Out-of-range: ACK in cycle 1.
  - Minimum spacing between grants: write 3 cycles, read 4 cycles.
- Requester protocol:
  - Hold REQ, RW, ADDRESS and data_in stable until ACK is sampled.
  - Drop REQ in the cycle after ACK.
  - A REQ dropped early still completes the latched transaction and is ACKed.
- Simultaneous requests: only one winner per IDLE cycle; losers wait, and there is no starvation (worst case 3 transactions ahead).
- REQ changes on non-granted ports while BUSY are ignored until the next IDLE.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP).
  - NUM_PORTS, DATA_W, ADDR_W, MEM_DEPTH and MEM_ADDR_W constants.
  - Port-index typedef, logic [1:0].
- Sub-module rr_arbiter: combinational; inputs req[3:0] and last_grant[1:0]; outputs any_req and winner[1:0].
- The FSM, latches and memory drive stay in mem_arbiter_rr.

Test Plan:
1. Reset; port 2 writes addr 0x05, data 0xA5 -> cycle 1: mem_en = 1, mem_we = 1, mem_addr = 5, mem_wdata = 0xA5; cycle 2: ACK[2] = 1, ERR = 0, BUSY drops in cycle 3.
2. Port 1 reads addr 0x05, memory model returns 0xA5 -> ACK[1] in cycle 3 with data_out = 0xA5; mem_en high only in cycle 1.
3. After reset, all four REQ high with writes and re-asserted after each ACK -> ACK order 0, 1, 2, 3, 0, spaced 3 cycles apart.
4. Port 3 reads addr 0x20 -> mem_en stays 0; ACK[3] = 1 and ERR = 1 in cycle 1; data_out = 0x00.
5. RESET asserted while in WAIT -> next cycle: all outputs 0, BUSY = 0; then ports 0 and 3 request together -> port 0 granted first.
6. Port 0 ACKed and re-requests immediately while port 2 is pending -> port 2 granted before port 0.
